// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: in-flight slot record,
// forward-select and result-ready encodings.
package hazard_pkg;

   // Slot fields are sized for the widest supported configuration
   // (REG_AW up to 8, DEPTH up to 8); narrower builds zero-extend into them.
   localparam int MAX_REG_AW = 8;
   localparam int MAX_SLOT_W = 4;

   localparam int FWD_RF   = 0;
   localparam int RDY_ALU  = 0;
   localparam int RDY_LOAD = 1;

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [MAX_REG_AW-1:0] dst;
      logic [MAX_SLOT_W-1:0] rdy;
   } slotT;

endpackage

// File: rtl/hazard_match.sv
// Combinational youngest-producer finder: reports whether any in-flight slot
// writes the given source register and, if so, the lowest matching slot index.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int SLOT_W = $clog2(DEPTH + 1),
   parameter int REG_AW = 5
) (
   input  slotT [DEPTH-1:0]  slots,
   input  logic [REG_AW-1:0] src,
   input  logic              srcUsed,
   output logic              found,
   output logic [SLOT_W-1:0] k
);

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path through
      // this block leaves a value unassigned and no latch is inferred.
      found = 1'b0;
      k     = '0;
      if (srcUsed && (src != '0)) begin
         // Scan oldest to youngest so the lowest index is the last one written.
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots[i].valid && slots[i].we && (slots[i].dst == MAX_REG_AW'(src))) begin
               found = 1'b1;
               k     = SLOT_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and stall controller for the in-order pipeline.
// Optional build macro HAZARD_HOLD_EN adds a back-end 'hold' input that freezes the pipeline.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3,
   parameter int SLOT_W = $clog2(DEPTH + 1),
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic              use_rs_d,
   input  logic              use_rt_d,
   input  logic [REG_AW-1:0] dst_d,
   input  logic              wr_d,
   input  logic [SLOT_W-1:0] rdy_d,
   input  logic              is_branch_d,
   input  logic              branch_taken_d,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic [SLOT_W-1:0] fwd_a_e,
   output logic [SLOT_W-1:0] fwd_b_e,
   output logic [CNT_W-1:0]  stall_cnt
`ifdef HAZARD_HOLD_EN
   ,
   input  logic              hold
`endif
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH - 1);

   slotT [DEPTH-1:0]  slots;
   slotT              newSlot;
   logic              holdInt;
   logic              foundA, foundB;
   logic [SLOT_W-1:0] kA, kB;
   logic              fwdableA, fwdableB;
   logic              dataHaz, branchHaz, hazard, issue;

`ifdef HAZARD_HOLD_EN
   assign holdInt = hold;
`else
   assign holdInt = 1'b0;
`endif

   hazard_match #(.DEPTH(DEPTH), .SLOT_W(SLOT_W), .REG_AW(REG_AW)) uMatchA (
      .slots   (slots),
      .src     (rs_d),
      .srcUsed (use_rs_d),
      .found   (foundA),
      .k       (kA)
   );

   hazard_match #(.DEPTH(DEPTH), .SLOT_W(SLOT_W), .REG_AW(REG_AW)) uMatchB (
      .slots   (slots),
      .src     (rt_d),
      .srcUsed (use_rt_d),
      .found   (foundB),
      .k       (kB)
   );

   // A producer in the last slot is written back this cycle and is read through the register file.
   assign fwdableA  = foundA && (kA < LAST_SLOT);
   assign fwdableB  = foundB && (kB < LAST_SLOT);
   assign dataHaz   = (foundA && (MAX_SLOT_W'(kA) < slots[kA].rdy))
                   || (foundB && (MAX_SLOT_W'(kB) < slots[kB].rdy));
   assign branchHaz = is_branch_d && (fwdableA || fwdableB);
   assign hazard    = id_valid && (dataHaz || branchHaz);

   always_comb begin
      stall_d = 1'b0;
      flush_e = 1'b0;
      flush_d = 1'b0;
      if (!rst) begin
         if (holdInt) begin
            stall_d = 1'b1;
         end else begin
            stall_d = hazard;
            flush_e = hazard || !id_valid;
            flush_d = branch_taken_d && !hazard;
         end
      end
   end

   assign stall_f = stall_d;
   assign issue   = id_valid && !stall_d;

   always_comb begin
      newSlot       = '0;
      newSlot.valid = issue;
      newSlot.we    = wr_d;
      newSlot.dst   = MAX_REG_AW'(dst_d);
      newSlot.rdy   = (int'(rdy_d) >= DEPTH) ? MAX_SLOT_W'(DEPTH - 1) : MAX_SLOT_W'(rdy_d);
      if (!issue) newSlot.rdy = MAX_SLOT_W'(RDY_ALU);
   end

   always_ff @(posedge clk) begin
      // NOTE: slots are ordinary registers rather than a RAM, so they take the
      // reset directly and a mid-run reset drops every in-flight write.
      if (rst) begin
         slots     <= '0;
         fwd_a_e   <= SLOT_W'(FWD_RF);
         fwd_b_e   <= SLOT_W'(FWD_RF);
         stall_cnt <= '0;
      end else if (!holdInt) begin
         // NOTE: non-blocking assignments let every slot read its neighbour's
         // pre-edge value, which is what makes this a shift register.
         for (int i = DEPTH - 1; i > 0; i--) slots[i] <= slots[i-1];
         slots[0] <= issue ? newSlot : slotT'('0);
         fwd_a_e  <= (issue && fwdableA) ? kA + SLOT_W'(1) : SLOT_W'(FWD_RF);
         fwd_b_e  <= (issue && fwdableB) ? kB + SLOT_W'(1) : SLOT_W'(FWD_RF);
         if (stall_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: each directed cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

   localparam int REG_AW = 5;
   localparam int DEPTH  = 3;
   localparam int SLOT_W = 2;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] rs_d = '0, rt_d = '0, dst_d = '0;
   logic              use_rs_d = 1'b0, use_rt_d = 1'b0, wr_d = 1'b0;
   logic [SLOT_W-1:0] rdy_d = '0;
   logic              is_branch_d = 1'b0, branch_taken_d = 1'b0;
   logic              hold = 1'b0;
   logic              stall_f, stall_d, flush_d, flush_e;
   logic [SLOT_W-1:0] fwd_a_e, fwd_b_e;
   logic [CNT_W-1:0]  stall_cnt;

   typedef struct {
      string             name;
      logic              st;
      logic              fe;
      logic              fd;
      logic [SLOT_W-1:0] fa;
      logic [SLOT_W-1:0] fb;
      logic [CNT_W-1:0]  cnt;
   } expT;

   expT expQ[$];
   int  compared   = 0;
   int  mismatched = 0;

   hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .rs_d           (rs_d),
      .rt_d           (rt_d),
      .use_rs_d       (use_rs_d),
      .use_rt_d       (use_rt_d),
      .dst_d          (dst_d),
      .wr_d           (wr_d),
      .rdy_d          (rdy_d),
      .is_branch_d    (is_branch_d),
      .branch_taken_d (branch_taken_d),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .fwd_a_e        (fwd_a_e),
      .fwd_b_e        (fwd_b_e),
      .stall_cnt      (stall_cnt)
`ifdef HAZARD_HOLD_EN
      ,
      .hold           (hold)
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         expT e;
         e = expQ.pop_front();
         check({e.name, ".stall_d"},   32'(stall_d),   32'(e.st));
         check({e.name, ".stall_f"},   32'(stall_f),   32'(e.st));
         check({e.name, ".flush_e"},   32'(flush_e),   32'(e.fe));
         check({e.name, ".flush_d"},   32'(flush_d),   32'(e.fd));
         check({e.name, ".fwd_a_e"},   32'(fwd_a_e),   32'(e.fa));
         check({e.name, ".fwd_b_e"},   32'(fwd_b_e),   32'(e.fb));
         check({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
      end
   end

   // One decode cycle: drive inputs just after the edge, queue what the outputs must show.
   task automatic step(
      input string nm, input logic r, input logic iv,
      input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
      input logic [4:0] dst, input logic wr, input logic [1:0] rdy,
      input logic br, input logic bt, input logic hd,
      input logic eSt, input logic eFe, input logic eFd,
      input logic [1:0] eFa, input logic [1:0] eFb, input int eCnt);
      expT e;
      @(posedge clk);
      #1;
      rst = r; id_valid = iv;
      rs_d = rs; use_rs_d = urs; rt_d = rt; use_rt_d = urt;
      dst_d = dst; wr_d = wr; rdy_d = rdy;
      is_branch_d = br; branch_taken_d = bt; hold = hd;
      e.name = nm; e.st = eSt; e.fe = eFe; e.fd = eFd;
      e.fa = eFa; e.fb = eFb; e.cnt = CNT_W'(eCnt);
      expQ.push_back(e);
   endtask

   initial begin
      //     name          r iv rs urs rt urt dst wr rdy br bt hd  st fe fd fa fb cnt
      step("reset",        1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      // back-to-back ALU forwarding
      step("alu_add",      0, 1, 1, 1, 2, 1,  3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("alu_sub",      0, 1, 3, 1, 0, 0,  8, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("alu_fwd1",     0, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
      step("alu_fwd2",     0, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0);
      // load-use: one stall then forward from slot 1
      step("lw",           0, 1,10, 1, 0, 0,  5, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("lu_stall",     0, 1,11, 1, 5, 1,  6, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      step("lu_issue",     0, 1,11, 1, 5, 1,  6, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      step("lu_fwd",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 2, 1);
      // branch in ID waits until the producer reaches WB
      step("br_prod",      0, 1, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      step("br_stall1",    0, 1, 4, 1, 0, 0,  0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 1);
      step("br_stall2",    0, 1, 4, 1, 0, 0,  0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 2);
      step("br_go",        0, 1, 4, 1, 0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 3);
      // $0 destination and unused sources never match
      step("z_prod",       0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("z_cons",       0, 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("u_prod",       0, 1, 0, 0, 0, 0,  7, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("u_cons",       0, 1, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("u_idle",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 3);
      // youngest producer wins, then a mid-run reset clears everything
      step("y_prod1",      0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("y_prod2",      0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("y_cons",       0, 1, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("y_rst",        1, 1, 2, 1, 0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0, 3);
      step("y_after",      0, 1, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("y_idle",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
      // rdy beyond the last slot saturates to DEPTH-1
      step("sat_prod",     0, 1, 0, 0, 0, 0,  9, 1, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      step("sat_stall1",   0, 1, 9, 1, 0, 0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      step("sat_stall2",   0, 1, 9, 1, 0, 0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
      step("sat_go",       0, 1, 9, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2);
      step("sat_idle",     0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 2);
`ifdef HAZARD_HOLD_EN
      // hold freezes slots, forward selects and the counter during a load-use stall
      step("h_prod",       0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2);
      step("h_lw",         0, 1,12, 1, 0, 0,  5, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2);
      for (int i = 0; i < 3; i++)
         step("h_hold",    0, 1, 0, 0, 5, 1,  6, 1, 0, 0, 0, 1,  1, 0, 0, 1, 0, 2);
      step("h_stall",      0, 1, 0, 0, 5, 1,  6, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 2);
      step("h_issue",      0, 1, 0, 0, 5, 1,  6, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
      step("h_idle",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 2, 3);
`endif
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (expQ.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
